mxint8_sum_ctrl: RTL

//  Beat-serial front end and sequencer for the combinational mxint8_sum datapath.
//  - Gathers one MXINT8 block (one scale + BLOCK_SIZE elements) from a LANES-wide

---
 rtl/mxint8_sum_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mxint8_sum_ctrl.sv
`default_nettype none

`ifndef SCALE_WIDTH
`define SCALE_WIDTH 8
`endif
`ifndef MXINT8_ELEMENT_WIDTH
`define MXINT8_ELEMENT_WIDTH 8
`endif
`ifndef FLOAT32_WIDTH
`define FLOAT32_WIDTH 32
`endif

// ============================================================================
// Module   : mxint8_sum_ctrl
// Purpose  : Beat-serial block gatherer and settle/capture sequencer for the
//            combinational mxint8_sum datapath. Optional MXINT8_SUM_CTRL_STATS_EN
//            adds block and overflow counters.
// Revision : 1.0 - initial release
// ============================================================================
module mxint8_sum_ctrl #(
   parameter int BLOCK_SIZE    = 32,
   parameter int LANES         = 8,
   parameter int SETTLE_CYCLES = 1,
   parameter int TAG_WIDTH     = 8
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic                                                s_valid,
   output logic                                                s_ready,
   input  logic [`SCALE_WIDTH-1:0]                             s_scale,
   input  logic [LANES-1:0][`MXINT8_ELEMENT_WIDTH-1:0]         s_elements,
   output logic [`SCALE_WIDTH-1:0]                             o_sum_scale,
   output logic [BLOCK_SIZE-1:0][`MXINT8_ELEMENT_WIDTH-1:0]    o_sum_elements,
   input  logic [`FLOAT32_WIDTH-1:0]                           i_sum_float32,
   input  logic                                                i_sum_overflow,
   output logic                                                m_valid,
   input  logic                                                m_ready,
   output logic [`FLOAT32_WIDTH-1:0]                           m_float32,
   output logic                                                m_overflow,
   output logic [TAG_WIDTH-1:0]                                m_tag
`ifdef MXINT8_SUM_CTRL_STATS_EN
   ,
   output logic [31:0]                                         o_blk_count,
   output logic [15:0]                                         o_ovf_count
`endif
);

   localparam int              BEATS       = BLOCK_SIZE / LANES;
   localparam int              BCW         = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BCW-1:0]  C_LAST_BEAT = BCW'(BEATS - 1);
   localparam logic [3:0]      C_SETTLE    = 4'(SETTLE_CYCLES);

   generate
      if (BLOCK_SIZE % LANES != 0) begin : g_bad_lanes
         $error("mxint8_sum_ctrl: BLOCK_SIZE must be a multiple of LANES");
      end
      if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
         $error("mxint8_sum_ctrl: SETTLE_CYCLES must be in 1..15");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_WAIT = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   state_t                                              r_state;
   state_t                                              w_state_next;
   logic [BCW-1:0]                                      r_beat_cnt;
   logic [3:0]                                          r_settle_cnt;
   logic [TAG_WIDTH-1:0]                                r_tag;
   logic [`SCALE_WIDTH-1:0]                             r_scale;
   logic [BEATS-1:0][LANES-1:0][`MXINT8_ELEMENT_WIDTH-1:0] r_buf;

   logic w_last_beat;
   logic w_accept;
   logic w_settle_done;
   logic w_m_hs;

   assign w_last_beat   = (r_beat_cnt == C_LAST_BEAT);
   assign w_accept      = s_valid & s_ready;
   assign w_settle_done = (r_state == ST_WAIT) && (r_settle_cnt == 4'd1);
   assign w_m_hs        = m_valid & m_ready;

   assign o_sum_scale    = r_scale;
   assign o_sum_elements = r_buf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_FILL;
      end else begin
         r_state <= w_state_next;
      end
   end

   // In OUT the result is already registered, so only the final beat must wait
   // for the output handshake before the buffer can be committed to WAIT.
   always_comb begin
      s_ready      = 1'b0;
      w_state_next = r_state;
      case (r_state)
         ST_FILL: begin
            s_ready = 1'b1;
            if (s_valid && w_last_beat) begin
               w_state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_settle_cnt == 4'd1) begin
               w_state_next = ST_OUT;
            end
         end
         ST_OUT: begin
            s_ready = !w_last_beat || m_ready;
            if (m_ready) begin
               w_state_next = (s_valid && w_last_beat) ? ST_WAIT : ST_FILL;
            end
         end
         default: begin
            w_state_next = ST_FILL;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_beat_cnt   <= '0;
         r_settle_cnt <= '0;
         r_tag        <= '0;
         r_scale      <= '0;
         r_buf        <= '0;
         m_valid      <= 1'b0;
         m_float32    <= '0;
         m_overflow   <= 1'b0;
         m_tag        <= '0;
      end else begin
         if (w_accept) begin
            r_buf[r_beat_cnt] <= s_elements;
            if (r_beat_cnt == '0) begin
               r_scale <= s_scale;
            end
            r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
         end

         if (w_accept && w_last_beat) begin
            r_settle_cnt <= C_SETTLE;
         end else if (r_state == ST_WAIT) begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
         end

         if (w_settle_done) begin
            m_float32  <= i_sum_float32;
            m_overflow <= i_sum_overflow;
            m_tag      <= r_tag;
            r_tag      <= r_tag + 1'b1;
            m_valid    <= 1'b1;
         end else if (w_m_hs) begin
            m_valid    <= 1'b0;
         end
      end
   end

`ifdef MXINT8_SUM_CTRL_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_blk_count <= '0;
         o_ovf_count <= '0;
      end else if (w_m_hs) begin
         o_blk_count <= o_blk_count + 32'd1;
         if (m_overflow && (o_ovf_count != 16'hFFFF)) begin
            o_ovf_count <= o_ovf_count + 16'd1;
         end
      end
   end
`endif

endmodule

`default_nettype wire
